// File: rtl/ss_pkg.sv
// Shared types and constants for the sidescroller map sequencing slice.
package ss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_BLANK = 2'd2
  } ss_seq_state_t;

  localparam int MAP_PART1 = 0;
  localparam int MAP_LR    = 1;
  localparam int MAP_LOOP  = 2;

  localparam logic [7:0] DEFAULT_EDGE_X = 8'h7C;

  // Successor map index: the last map wraps back into the loop map.
  function automatic int next_map_idx(input int cur, input int num_maps, input int loop_map);
    if (cur == num_maps - 1) begin
      return loop_map;
    end else begin
      return cur + 1;
    end
  endfunction

endpackage

// File: rtl/ss_locx_edge_det.sv
// Rising-match detector on a tile column: fires once when loc_x first equals EDGE_VAL.
// Parameterised on the compare value so other trigger columns can reuse it.
module ss_locx_edge_det #(
  parameter logic [7:0] EDGE_VAL = 8'h7C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] loc_x,
  output logic       edge_hit
);

  logic [7:0] locx_q;

  // Previous-cycle column, used to suppress repeat hits while the column is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      locx_q <= 8'h00;
    end else begin
      locx_q <= loc_x;
    end
  end

  assign edge_hit = (loc_x == EDGE_VAL) && (locx_q != EDGE_VAL);

endmodule

// File: rtl/ss_map_sequencer.sv
// World-map sequencer: advances map_sel on screen-edge hits and blanks video around switches.
// Optional SS_MAP_SW_OVERRIDE_EN adds a switch-driven map select while playing.
module ss_map_sequencer
  import ss_pkg::*;
#(
  parameter int         NUM_MAPS     = 3,
  parameter int         MAP_W        = 2,
  parameter logic [7:0] EDGE_X       = DEFAULT_EDGE_X,
  parameter int         LOOP_MAP     = 1,
  parameter int         BLANK_FRAMES = 4
) (
  input  logic             clk_75,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             start,
  input  logic [7:0]       LocX,
  input  logic             player_dead,
`ifdef SS_MAP_SW_OVERRIDE_EN
  input  logic             sw_override,
  input  logic [MAP_W-1:0] sw_map,
`endif
  output logic [MAP_W-1:0] map_sel,
  output logic             blank,
  output logic             map_changed,
  output logic [3:0]       level_count
);

  localparam logic [3:0]       BLANK_LOAD = 4'(BLANK_FRAMES);
  localparam logic [MAP_W-1:0] LAST_MAP   = MAP_W'(NUM_MAPS - 1);

  ss_seq_state_t    state_r, state_nxt_s;
  logic [3:0]       blank_cnt_r, cnt_nxt_s;
  logic             adv_r, adv_nxt_s;
  logic [MAP_W-1:0] map_sel_r, map_nxt_s;
  logic             changed_r, changed_nxt_s;
  logic [3:0]       level_count_r, lvl_nxt_s;
  logic             blank_r;
  logic             edge_hit_s;
  logic [MAP_W-1:0] map_succ_s;

  ss_locx_edge_det #(
    .EDGE_VAL (EDGE_X)
  ) u_edge_det (
    .clk      (clk_75),
    .reset    (reset),
    .loc_x    (LocX),
    .edge_hit (edge_hit_s)
  );

  assign map_succ_s = MAP_W'(next_map_idx(int'(map_sel_r), NUM_MAPS, LOOP_MAP));

`ifdef SS_MAP_SW_OVERRIDE_EN
  logic [MAP_W-1:0] sw_clamp_s;
  assign sw_clamp_s = (sw_map > LAST_MAP) ? LAST_MAP : sw_map;
`endif

  // Next-state, blank counter, map and level bookkeeping.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = blank_cnt_r;
    adv_nxt_s     = adv_r;
    map_nxt_s     = map_sel_r;
    changed_nxt_s = 1'b0;
    lvl_nxt_s     = level_count_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        // Death outranks an edge hit in the same cycle: no advance is queued.
        if (player_dead) begin
          state_nxt_s = ST_BLANK;
          adv_nxt_s   = 1'b0;
          cnt_nxt_s   = BLANK_LOAD;
        end else if (edge_hit_s) begin
          state_nxt_s = ST_BLANK;
          adv_nxt_s   = 1'b1;
          cnt_nxt_s   = BLANK_LOAD;
        end else begin
          state_nxt_s = ST_PLAY;
        end
`ifdef SS_MAP_SW_OVERRIDE_EN
        if (sw_override && frame_tick) begin
          map_nxt_s     = sw_clamp_s;
          changed_nxt_s = (sw_clamp_s != map_sel_r);
        end else begin
          map_nxt_s     = map_sel_r;
        end
`endif
      end
      ST_BLANK: begin
        if (frame_tick) begin
          // adv_r is consumed on the first frame so the map moves exactly once.
          if (adv_r) begin
            map_nxt_s     = map_succ_s;
            changed_nxt_s = 1'b1;
            adv_nxt_s     = 1'b0;
            if (level_count_r != 4'd15) begin
              lvl_nxt_s = level_count_r + 4'd1;
            end else begin
              lvl_nxt_s = level_count_r;
            end
          end else begin
            adv_nxt_s = 1'b0;
          end
          cnt_nxt_s = blank_cnt_r - 4'd1;
          if (blank_cnt_r == 4'd1) begin
            state_nxt_s = ST_PLAY;
          end else begin
            state_nxt_s = ST_BLANK;
          end
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; blank follows the state being entered.
  always_ff @(posedge clk_75) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      blank_cnt_r   <= 4'd0;
      adv_r         <= 1'b0;
      map_sel_r     <= {MAP_W{1'b0}};
      changed_r     <= 1'b0;
      level_count_r <= 4'd0;
      blank_r       <= 1'b1;
    end else begin
      state_r       <= state_nxt_s;
      blank_cnt_r   <= cnt_nxt_s;
      adv_r         <= adv_nxt_s;
      map_sel_r     <= map_nxt_s;
      changed_r     <= changed_nxt_s;
      level_count_r <= lvl_nxt_s;
      blank_r       <= (state_nxt_s != ST_PLAY);
    end
  end

  assign map_sel     = map_sel_r;
  assign blank       = blank_r;
  assign map_changed = changed_r;
  assign level_count = level_count_r;

endmodule
